// File: rtl/shift_wb_queue_if.sv
// Shift-unit writeback bundle: incoming results, per-hart kill, and the commit write port.
// No storage of its own; all timing is set by the queue that owns the slave side.
// The wb_valid/wb_ready pair carries the write-port grant back into the queue.
interface shift_wb_queue_if #(
  parameter int RV       = 64,
  parameter int LNCOMMIT = 5,
  parameter int NHART    = 1,
  parameter int LDEPTH   = 2
);
  logic [RV-1:0]       in_result;
  logic [LNCOMMIT-1:0] in_rd;
  logic [NHART-1:0]    in_makes_rd;
  logic [NHART-1:0]    kill;
  logic                wb_ready;
  logic                wb_valid;
  logic [RV-1:0]       wb_data;
  logic [LNCOMMIT-1:0] wb_rd;
  logic [NHART-1:0]    wb_makes_rd;
  logic                issue_stall;
  logic [LDEPTH:0]     count;
  logic                overflow;

  // Producer / commit side: drives results, kills and the write-port grant.
  modport master (
    output in_result, in_rd, in_makes_rd, kill, wb_ready,
    input  wb_valid, wb_data, wb_rd, wb_makes_rd, issue_stall, count, overflow
  );

  // Queue side.
  modport slave (
    input  in_result, in_rd, in_makes_rd, kill, wb_ready,
    output wb_valid, wb_data, wb_rd, wb_makes_rd, issue_stall, count, overflow
  );
endinterface

// File: rtl/shift_wb_queue.sv
// Ring-buffer writeback queue behind the shift unit, draining in order to the commit write port.
// Latency: a result captured at edge N is presented at the head no earlier than cycle N+1.
// Backpressure: wb_ready stalls the head; issue_stall rises while free slots <= SKID; a push with no room is dropped and sets sticky overflow.
module shift_wb_queue #(
  parameter int RV       = 64,
  parameter int LNCOMMIT = 5,
  parameter int NHART    = 1,
  parameter int DEPTH    = 4,
  parameter int LDEPTH   = 2,
  parameter int SKID     = 2
) (
  input logic            clk,
  input logic            reset,
  shift_wb_queue_if.slave wb
);

  typedef logic [LDEPTH:0]   ptr_t;
  typedef logic [LDEPTH-1:0] idx_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t SKID_P  = ptr_t'(SKID);

  // Slot storage. Only r_valid needs a reset; payload is qualified by it.
  logic [DEPTH-1:0]    r_valid;
  logic [RV-1:0]       r_data [DEPTH];
  logic [LNCOMMIT-1:0] r_rd   [DEPTH];
  logic [NHART-1:0]    r_hart [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  ptr_t r_head;
  ptr_t r_tail;
  logic r_overflow;

  idx_t             w_head_idx;
  idx_t             w_tail_idx;
  ptr_t             w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_head_killed;
  logic             w_wb_valid;
  logic             w_pop;
  logic             w_skip;
  logic             w_advance;
  logic             w_push_req;
  logic             w_push_ok;
  logic             w_push_drop;
  logic [DEPTH-1:0] w_valid_nxt;

  assign w_head_idx = r_head[LDEPTH-1:0];
  assign w_tail_idx = r_tail[LDEPTH-1:0];
  assign w_count    = r_tail - r_head;
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (w_count == DEPTH_P);

  // A head entry whose hart is being flushed this cycle must not reach the write port,
  // even though its valid bit only clears at the next edge.
  assign w_head_killed = |(r_hart[w_head_idx] & wb.kill);
  assign w_wb_valid    = !w_empty && r_valid[w_head_idx] && !w_head_killed;

  // Head moves on a real transfer, or past a hole left by an earlier kill. The two are
  // mutually exclusive since a hole is never valid.
  assign w_pop     = w_wb_valid && wb.wb_ready;
  assign w_skip    = !w_empty && !r_valid[w_head_idx];
  assign w_advance = w_pop || w_skip;

  // An incoming result for a hart being flushed in the same cycle is simply never written.
  // When full, a push still fits if the head slot is being vacated on this edge.
  assign w_push_req  = |(wb.in_makes_rd & ~wb.kill);
  assign w_push_ok   = w_push_req && (!w_full || w_advance);
  assign w_push_drop = w_push_req && !w_push_ok;

  // Next valid vector: kill punches holes, the head slot is released when it advances,
  // and the tail write wins last (it may reuse the slot the head is leaving).
  always_comb begin
    w_valid_nxt = r_valid;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && |(r_hart[i] & wb.kill)) begin
        w_valid_nxt[i] = 1'b0;
      end
      if (w_advance && (w_head_idx == idx_t'(i))) begin
        w_valid_nxt[i] = 1'b0;
      end
      if (w_push_ok && (w_tail_idx == idx_t'(i))) begin
        w_valid_nxt[i] = 1'b1;
      end
    end
  end

  // Valid bits, pointers and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      if (w_advance) begin
        r_head <= r_head + ptr_t'(1);
      end
      if (w_push_ok) begin
        r_tail <= r_tail + ptr_t'(1);
      end
      if (w_push_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Payload capture into the tail slot.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_data[w_tail_idx] <= wb.in_result;
      r_rd[w_tail_idx]   <= wb.in_rd;
      r_hart[w_tail_idx] <= wb.in_makes_rd;
    end
  end

  assign wb.wb_valid    = w_wb_valid;
  assign wb.wb_data     = r_data[w_head_idx];
  assign wb.wb_rd       = r_rd[w_head_idx];
  assign wb.wb_makes_rd = w_wb_valid ? r_hart[w_head_idx] : '0;
  assign wb.count       = w_count;
  assign wb.overflow    = r_overflow;

  // Holes count as occupied, so the stall stays conservative until they are skipped.
  assign wb.issue_stall = ((DEPTH_P - w_count) <= SKID_P);

endmodule

// File: tb/tb_shift_wb_queue.sv
module tb_shift_wb_queue;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic [1:0]  hart;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  exp_t sb[$];

  shift_wb_queue_if #(.RV(64), .LNCOMMIT(5), .NHART(2), .LDEPTH(2)) wb ();

  shift_wb_queue #(
    .RV(64), .LNCOMMIT(5), .NHART(2), .DEPTH(4), .LDEPTH(2), .SKID(2)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .wb    (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every transfer at the write port is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && wb.wb_valid && wb.wb_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_transfer_rd", {59'd0, wb.wb_rd}, 64'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_rd",   {59'd0, wb.wb_rd}, {59'd0, e.rd});
        check("sb_data", wb.wb_data, e.data);
        check("sb_hart", {62'd0, wb.wb_makes_rd}, {62'd0, e.hart});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push(input logic [1:0] h, input logic [4:0] rd, input logic [63:0] d,
                      input bit accept);
    exp_t e;
    wb.in_makes_rd = h;
    wb.in_rd       = rd;
    wb.in_result   = d;
    if (accept) begin
      e.rd = rd; e.data = d; e.hart = h;
      sb.push_back(e);
    end
    step();
    wb.in_makes_rd = 2'b00;
  endtask

  task automatic drain(input string name);
    wb.wb_ready = 1'b1;
    for (int c = 0; c < 20 && (sb.size() != 0 || wb.count != 0); c++) step();
    sample();
    check({name, "_count"}, {61'd0, wb.count}, 64'd0);
    check({name, "_sb_left"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    wb.in_makes_rd = 2'b00;
    wb.kill        = 2'b00;
    wb.wb_ready    = 1'b0;
    rst_n = 1'b0;
    #2;
    check("rst_count", {61'd0, wb.count}, 64'd0);
    check("rst_wb_valid", {63'd0, wb.wb_valid}, 64'd0);
    sb.delete();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    wb.in_result   = '0;
    wb.in_rd       = '0;
    wb.in_makes_rd = 2'b00;
    wb.kill        = 2'b00;
    wb.wb_ready    = 1'b0;
    step();
    sample();
    check("init_wb_valid",    {63'd0, wb.wb_valid}, 64'd0);
    check("init_makes_rd",    {62'd0, wb.wb_makes_rd}, 64'd0);
    check("init_issue_stall", {63'd0, wb.issue_stall}, 64'd0);
    check("init_count",       {61'd0, wb.count}, 64'd0);
    check("init_overflow",    {63'd0, wb.overflow}, 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // 1. Reset mid-stream, then a push right after release.
    push(2'b01, 5'd7, 64'hA1, 1'b1);
    push(2'b01, 5'd8, 64'hA2, 1'b1);
    push(2'b01, 5'd9, 64'hA3, 1'b1);
    sample();
    check("t1_pre_count", {61'd0, wb.count}, 64'd3);
    step();
    rst_n = 1'b0;
    #2;
    check("t1_rst_count",    {61'd0, wb.count}, 64'd0);
    check("t1_rst_wb_valid", {63'd0, wb.wb_valid}, 64'd0);
    check("t1_rst_stall",    {63'd0, wb.issue_stall}, 64'd0);
    sb.delete();
    step();
    rst_n = 1'b1;
    push(2'b01, 5'd10, 64'hB0B0, 1'b1);
    sample();
    check("t1_post_count", {61'd0, wb.count}, 64'd1);
    check("t1_post_valid", {63'd0, wb.wb_valid}, 64'd1);
    drain("t1_drain");

    // 2. Single push with the port granting: visible one cycle later, gone the cycle after.
    wb.wb_ready = 1'b1;
    push(2'b01, 5'd5, 64'h0123_4567_89AB_CDEF, 1'b1);
    sample();
    check("t2_wb_valid", {63'd0, wb.wb_valid}, 64'd1);
    check("t2_wb_rd",    {59'd0, wb.wb_rd}, 64'd5);
    check("t2_wb_data",  wb.wb_data, 64'h0123_4567_89AB_CDEF);
    check("t2_makes_rd", {62'd0, wb.wb_makes_rd}, 64'd1);
    step();
    sample();
    check("t2_count_after", {61'd0, wb.count}, 64'd0);
    check("t2_valid_after", {63'd0, wb.wb_valid}, 64'd0);

    // 3. Fill with the port blocked, stall threshold, overflow, then in-order drain.
    wb.wb_ready = 1'b0;
    step();
    push(2'b01, 5'd1, 64'h1001, 1'b1);
    sample();
    check("t3_stall_c1", {63'd0, wb.issue_stall}, 64'd0);
    push(2'b01, 5'd2, 64'h1002, 1'b1);
    sample();
    check("t3_count_c2", {61'd0, wb.count}, 64'd2);
    check("t3_stall_c2", {63'd0, wb.issue_stall}, 64'd1);
    push(2'b01, 5'd3, 64'h1003, 1'b1);
    push(2'b01, 5'd4, 64'h1004, 1'b1);
    sample();
    check("t3_count_full", {61'd0, wb.count}, 64'd4);
    check("t3_ovf_before", {63'd0, wb.overflow}, 64'd0);
    push(2'b01, 5'd9, 64'hDEAD, 1'b0);
    sample();
    check("t3_ovf_after",   {63'd0, wb.overflow}, 64'd1);
    check("t3_count_after", {61'd0, wb.count}, 64'd4);
    drain("t3_drain");
    check("t3_ovf_sticky", {63'd0, wb.overflow}, 64'd1);

    // 4. Full queue, push and pop in the same cycle.
    step();
    do_reset();
    push(2'b01, 5'd11, 64'h2011, 1'b1);
    push(2'b01, 5'd12, 64'h2012, 1'b1);
    push(2'b01, 5'd13, 64'h2013, 1'b1);
    push(2'b01, 5'd14, 64'h2014, 1'b1);
    wb.wb_ready = 1'b1;
    push(2'b01, 5'd15, 64'h2015, 1'b1);
    wb.wb_ready = 1'b0;
    sample();
    check("t4_count",    {61'd0, wb.count}, 64'd4);
    check("t4_overflow", {63'd0, wb.overflow}, 64'd0);
    check("t4_head_rd",  {59'd0, wb.wb_rd}, 64'd12);
    drain("t4_drain");

    // 5. Two harts, flush hart 1 while the port grants; hart-0 entries leave in order.
    wb.wb_ready = 1'b0;
    step();
    push(2'b01, 5'd1, 64'h3001, 1'b1);
    push(2'b10, 5'd2, 64'h3002, 1'b1);
    push(2'b01, 5'd3, 64'h3003, 1'b1);
    push(2'b10, 5'd4, 64'h3004, 1'b1);
    wb.kill     = 2'b10;
    wb.wb_ready = 1'b1;
    begin
      exp_t keep[$];
      foreach (sb[i]) if ((sb[i].hart & 2'b10) == 2'b00) keep.push_back(sb[i]);
      sb = keep;
    end
    step();
    wb.kill = 2'b00;
    sample();
    check("t5_count_holes", {61'd0, wb.count}, 64'd3);
    check("t5_hole_valid",  {63'd0, wb.wb_valid}, 64'd0);
    check("t5_stall_holes", {63'd0, wb.issue_stall}, 64'd1);
    drain("t5_drain");

    // 6. Kill coinciding with a push of the same hart; then a push of the other hart.
    wb.wb_ready = 1'b0;
    step();
    wb.kill = 2'b01;
    push(2'b01, 5'd6, 64'h4006, 1'b0);
    wb.kill = 2'b00;
    sample();
    check("t6_same_count", {61'd0, wb.count}, 64'd0);
    check("t6_same_valid", {63'd0, wb.wb_valid}, 64'd0);
    wb.kill = 2'b01;
    push(2'b10, 5'd7, 64'h4007, 1'b1);
    wb.kill = 2'b00;
    sample();
    check("t6_other_count", {61'd0, wb.count}, 64'd1);
    check("t6_other_hart",  {62'd0, wb.wb_makes_rd}, 64'd2);
    drain("t6_drain");

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
